cr_kme_fifo_reader: RTL

- Read-side consumer for the KME 83-bit entry FIFO. Pops entries using the FIFO's valid/ack interface, one pop per acked cycle.
- Assembles each multi-beat command (up to MAX_BEATS 64-bit beats) into one wide block and presents it to downstream KME logic (key-op decode) over a valid/ready handshake.
- Flags framing errors per block.

---
 rtl/cr_kme_fifo_reader_pkg.sv | 24 ++
 rtl/cr_kme_fifo_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_reader_pkg.sv
// Shared definitions for the KME FIFO read-side block assembler.
// Holds the bit layout of one 83-bit FIFO entry and the assembler state enum.
// Entry layout: [82] last, [81:72] ctx id, [71:64] byte-valid mask, [63:0] data.
package cr_kme_fifo_reader_pkg;

    localparam int LAST_BIT = 82;
    localparam int CTX_MSB  = 81;
    localparam int CTX_LSB  = 72;
    localparam int MASK_MSB = 71;
    localparam int MASK_LSB = 64;
    localparam int DATA_W   = 64;
    localparam int CTX_W    = 10;
    localparam int MASK_W   = MASK_MSB - MASK_LSB + 1;
    localparam int ENTRY_W  = LAST_BIT + 1;
    // One assembly slot keeps a beat's mask on top of its data.
    localparam int SLOT_W   = MASK_W + DATA_W;

    // COLLECT gathers beats of a command; HOLD presents the finished block.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/cr_kme_fifo_reader.sv
// Read-side consumer of the KME entry FIFO.
// Pops entries with a valid/ack strobe, assembles the beats of one command
// into a wide block and hands it downstream over a valid/ready handshake,
// flagging framing errors (ctx mismatch, overrun, empty byte mask).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fifo_out            FIFO head entry {last, ctx, mask, data}
//   fifo_out_valid      FIFO non-empty
//   fifo_out_ack        pop strobe (combinational), FIFO reads on valid&ack
//   blk_data/blk_mask   assembled beats, beat i at slice i
//   blk_ctx             ctx id of the block's first beat
//   blk_beats           number of beats stored
//   blk_err             framing error seen in this block
//   blk_valid/blk_ready block handshake
//   busy                a block is partially collected
module cr_kme_fifo_reader
    import cr_kme_fifo_reader_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ENTRY_W-1:0]        fifo_out,
    input  logic                      fifo_out_valid,
    output logic                      fifo_out_ack,
    output logic [64*MAX_BEATS-1:0]   blk_data,
    output logic [8*MAX_BEATS-1:0]    blk_mask,
    output logic [CTX_W-1:0]          blk_ctx,
    output logic [BW-1:0]             blk_beats,
    output logic                      blk_err,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      busy
);

    localparam logic [BW-1:0] CNT_FULL = BW'(MAX_BEATS);

    state_e             state_q, state_d;
    logic [BW-1:0]      cnt_q, cnt_d;
    logic [CTX_W-1:0]   ctx_q, ctx_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               entLast;
    logic [CTX_W-1:0]   entCtx;
    logic [MASK_W-1:0]  entMask;
    logic [DATA_W-1:0]  entData;
    logic               pop;
    logic               handoff;
    logic [BW-1:0]      baseCnt;
    logic               baseErr;
    logic               full;

    assign entLast = fifo_out[LAST_BIT];
    assign entCtx  = fifo_out[CTX_MSB:CTX_LSB];
    assign entMask = fifo_out[MASK_MSB:MASK_LSB];
    assign entData = fifo_out[DATA_W-1:0];

    // The FIFO may pop whenever we are collecting, or when the held block is
    // leaving this cycle; ack never rises without valid.
    assign fifo_out_ack = fifo_out_valid & ((state_q != HOLD) | blk_ready);
    assign pop          = fifo_out_valid & fifo_out_ack;
    assign handoff      = (state_q == HOLD) & blk_ready;

    // A handoff empties the assembly first, so a beat popped in the same
    // cycle lands as beat 0 of the next block with a clean error flag.
    assign baseCnt = handoff ? '0 : cnt_q;
    assign baseErr = handoff ? 1'b0 : err_q;
    assign full    = (baseCnt == CNT_FULL);

    // Next-state logic for the beat counter, ctx latch, error flag and FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        err_d   = err_q;
        if (handoff) begin
            state_d = COLLECT;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
        if (pop) begin
            if (baseCnt == '0) begin
                ctx_d = entCtx;
            end
            cnt_d   = full ? baseCnt : baseCnt + BW'(1);
            err_d   = baseErr | (entMask == '0) | full
                    | ((baseCnt != '0) && (entCtx != ctx_q));
            state_d = entLast ? HOLD : COLLECT;
        end
        valid_d = (state_d == HOLD);
        busy_d  = (state_d == COLLECT) && (cnt_d != '0);
    end

    // State and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            ctx_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctx_q   <= ctx_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Assembly slots: each is written by the pop that targets its index and
    // zeroed on handoff, so unused beats always read as zero.
    for (genvar i = 0; i < MAX_BEATS; i++) begin : gSlot
        logic [SLOT_W-1:0] slot_q;
        logic              slotWe;

        assign slotWe = pop && (baseCnt == BW'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (slotWe) begin
                slot_q <= {entMask, entData};
            end else if (handoff) begin
                slot_q <= '0;
            end
        end

        assign blk_data[64*i +: 64] = slot_q[DATA_W-1:0];
        assign blk_mask[8*i +: 8]   = slot_q[SLOT_W-1:DATA_W];
    end

    assign blk_ctx   = ctx_q;
    assign blk_beats = cnt_q;
    assign blk_err   = err_q;
    assign blk_valid = valid_q;
    assign busy      = busy_q;

endmodule
